// File: rtl/fir4_inv_u.sv
// Inverse of a 4-tap moving-sum filter: recovers x_k from s_k with a one-entry
// ready/valid output buffer, a saturating "primed" counter and a sticky range error.
module fir4_inv_u #(
    parameter int w = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [w+1:0] s,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [w-1:0] a,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         primed,
    output logic         err
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t              state;
    state_t              state_next;
    logic [w+1:0]        prior_sum;
    logic [w-1:0]        shift [4];
    logic [2:0]          count;
    logic                accept;
    logic signed [w+3:0] r;
    logic                out_of_range;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // x_k = s_k - s_(k-1) + x_(k-4); shift[3] holds x_(k-4) when s_k arrives
    assign r = $signed({2'b00, s}) - $signed({2'b00, prior_sum})
             + $signed({4'b0000, shift[3]});

    // Any nonzero bit above the w-bit field means negative or too large
    assign out_of_range = (r[w+3:w] != 4'b0000);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (accept) state_next = FULL;
            FULL: begin
                if (accept) begin
                    state_next = FULL;
                end else if (out_ready) begin
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state == FULL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prior_sum <= '0;
            for (int i = 0; i < 4; i++) begin
                shift[i] <= '0;
            end
            count  <= '0;
            a      <= '0;
            primed <= 1'b0;
            err    <= 1'b0;
        end else if (accept) begin
            prior_sum <= s;
            shift[0]  <= r[w-1:0];
            shift[1]  <= shift[0];
            shift[2]  <= shift[1];
            shift[3]  <= shift[2];
            a         <= r[w-1:0];
            if (count != 3'd4) begin
                count <= count + 3'd1;
            end
            // primed follows the count after this acceptance
            primed <= (count >= 3'd3);
            err    <= err | out_of_range;
        end
    end

endmodule

// File: tb/tb_fir4_inv_u.sv
// Directed and randomized bench for fir4_inv_u, checked cycle by cycle against
// a transaction-level model of the moving-sum inverse and the output handshake.
module tb_fir4_inv_u;

    localparam int W = 16;
    localparam longint MASK = (64'd1 << W) - 1;

    logic           clk = 1'b0;
    logic           reset;
    logic [W+1:0]   s;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic           out_valid;
    logic           out_ready;
    logic           primed;
    logic           err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    longint xhist[$];
    longint sprev;
    longint exp_a;
    bit     exp_valid;
    bit     exp_err;
    int     nacc;

    // Generator for well-formed moving-sum streams in the random phase
    longint gen[$];
    longint cand;

    fir4_inv_u #(.w(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .s         (s),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .primed    (primed),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        xhist.delete();
        sprev     = 0;
        exp_a     = 0;
        exp_valid = 0;
        exp_err   = 0;
        nacc      = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".out_valid"}, longint'(out_valid), longint'(exp_valid));
        check({tag, ".primed"}, longint'(primed), longint'(nacc >= 4));
        check({tag, ".err"}, longint'(err), longint'(exp_err));
        if (exp_valid || nacc == 0) begin
            check({tag, ".a"}, longint'(a), exp_a);
        end
    endtask

    // One clock: drive inputs, check in_ready, advance model at the edge, check outputs.
    // Returns whether the model saw an acceptance.
    task automatic step(input string tag, input bit rst, input bit iv,
                        input longint sv, input bit ordy, output bit accepted);
        bit     rdy;
        longint r;
        @(negedge clk);
        reset     = rst;
        in_valid  = iv;
        s         = sv[W+1:0];
        out_ready = ordy;
        #1;
        rdy = !exp_valid || ordy;
        check({tag, ".in_ready"}, longint'(in_ready), longint'(rdy));
        @(posedge clk);
        accepted = 0;
        if (rst) begin
            model_reset();
        end else if (iv && rdy) begin
            accepted = 1;
            r = longint'(sv[W+1:0]) - sprev
              + ((xhist.size() >= 4) ? xhist[xhist.size() - 4] : 64'sd0);
            if (r < 0 || r > MASK) exp_err = 1;
            xhist.push_back(r & MASK);
            exp_a     = r & MASK;
            sprev     = longint'(sv[W+1:0]);
            exp_valid = 1;
            nacc++;
        end else if (exp_valid && ordy) begin
            exp_valid = 0;
        end
        #1;
        check_outputs(tag);
    endtask

    initial begin
        bit acc;
        longint ramp[5];
        longint full[5];
        ramp = '{1, 3, 6, 10, 14};
        full = '{65535, 131070, 196605, 262140, 262140};

        reset = 1'b1; in_valid = 1'b0; s = '0; out_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset_state");
        check("reset_in_ready", longint'(in_ready), 1);

        // Ramp at full throughput
        foreach (ramp[i]) step("ramp", 0, 1, ramp[i], 1, acc);
        check("ramp_last_a", longint'(a), 5);
        check("ramp_primed", longint'(primed), 1);
        step("ramp_drain", 0, 0, 0, 1, acc);

        // Full-scale samples
        step("fs_reset", 1, 0, 0, 1, acc);
        foreach (full[i]) begin
            step("fullscale", 0, 1, full[i], 1, acc);
            check("fullscale_a", longint'(a), 65535);
        end
        step("fs_drain", 0, 0, 0, 1, acc);

        // Backpressure after the first output; stalled sample is re-presented
        step("bp_reset", 1, 0, 0, 1, acc);
        step("bp_first", 0, 1, 1, 1, acc);
        repeat (3) begin
            step("bp_stall", 0, 1, 3, 0, acc);
            check("bp_hold_a", longint'(a), 1);
        end
        for (int i = 1; i < 5; i++) begin
            step("bp_resume", 0, 1, ramp[i], 1, acc);
            check("bp_order_a", longint'(a), i + 1);
        end
        step("bp_drain", 0, 0, 0, 1, acc);

        // Bubbles: invalid cycles carry junk that must be ignored
        step("bub_reset", 1, 0, 0, 1, acc);
        foreach (ramp[i]) begin
            step("bub_valid", 0, 1, ramp[i], 1, acc);
            step("bub_gap", 0, 0, $urandom_range(0, 262143), 1, acc);
            check("bub_gap_valid", longint'(out_valid), 0);
        end

        // Negative reconstruction sets a sticky error
        step("err_reset", 1, 0, 0, 1, acc);
        step("err_s5", 0, 1, 5, 1, acc);
        step("err_s0", 0, 1, 0, 1, acc);
        check("err_a", longint'(a), 'hFFFB);
        check("err_flag", longint'(err), 1);
        step("err_more1", 0, 1, 7, 1, acc);
        step("err_more2", 0, 1, 9, 1, acc);
        step("err_idle", 0, 0, 0, 1, acc);
        check("err_sticky", longint'(err), 1);

        // Reset in the middle of a stream discards history
        step("mid_reset0", 1, 0, 0, 1, acc);
        step("mid_s1", 0, 1, 1, 1, acc);
        step("mid_s3", 0, 1, 3, 1, acc);
        step("mid_s6", 0, 1, 6, 1, acc);
        step("mid_reset", 1, 1, 10, 1, acc);
        step("mid_s2", 0, 1, 2, 1, acc);
        check("mid_a0", longint'(a), 2);
        step("mid_s4", 0, 1, 4, 1, acc);
        check("mid_a1", longint'(a), 2);
        check("mid_primed", longint'(primed), 0);
        check("mid_err", longint'(err), 0);

        // Randomized traffic: mostly well-formed sums, occasional raw values and resets
        step("rnd_reset", 1, 0, 0, 1, acc);
        gen.delete();
        cand = $urandom_range(0, 65535);
        for (int c = 0; c < 400; c++) begin
            bit     rst;
            bit     iv;
            bit     ordy;
            bit     raw;
            longint sv;
            rst  = ($urandom_range(0, 63) == 0);
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            raw  = ($urandom_range(0, 31) == 0);
            sv   = cand;
            for (int j = 0; j < 3; j++) begin
                if (gen.size() > j) sv += gen[gen.size() - 1 - j];
            end
            if (raw) sv = $urandom_range(0, 262143);
            step("random", rst, iv, sv, ordy, acc);
            if (rst) begin
                gen.delete();
            end else if (acc) begin
                gen.push_back(cand);
                cand = $urandom_range(0, 65535);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir4_inv_u.md
FIR4_INV_U -- requirements
Module: fir4_inv_u

Interface
REQ-001 SHALL have parameter w, default 16, the reconstructed sample width; the sum width is w+2.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port s  input  w+2  4-tap moving sum, unsigned, the decoder input.
REQ-005 SHALL have port in_valid  input  1  s is valid this cycle.
REQ-006 SHALL have port in_ready  output  1  block accepts s this cycle.
REQ-007 SHALL have port a  output  w  reconstructed sample, unsigned.
REQ-008 SHALL have port out_valid  output  1  a is valid.
REQ-009 SHALL have port out_ready  input  1  downstream consumes a this cycle.
REQ-010 SHALL have port primed  output  1  at least 4 samples reconstructed since reset.
REQ-011 SHALL have port err  output  1  sticky flag: a reconstruction fell outside [0, 2^w-1].
REQ-012 SHALL use one clock, clk; reset SHALL be synchronous and active-high.

Function
REQ-013 Decoder model: the input stream is s_k = x_k + x_(k-1) + x_(k-2) + x_(k-3), with x_j = 0 for j<0.
REQ-014 Recovery rule: x_k = s_k - s_(k-1) + x_(k-4), with s_(-1) = 0 and x_j = 0 for j<0.
REQ-015 History state: one prior-sum register, w+2 bits; a 4-deep shift of recovered samples, w bits each. All history is zero after reset.
REQ-016 Arithmetic: signed, w+4 bits, no intermediate overflow. The result is r_k.
REQ-017 If r_k < 0 or r_k > 2^w-1, err SHALL set one cycle after acceptance and hold until reset.
REQ-018 In the out-of-range case, a, the shift entry and the next x_(k-4) SHALL all use r_k[w-1:0].
REQ-019 Acceptance: a sample is accepted when in_valid && in_ready.
REQ-020 in_ready = !out_valid || out_ready, combinational.
REQ-021 History updates only on acceptance:
  - prior-sum <= s
  - shift <= {r_k[w-1:0], shift[0:2]}
REQ-022 Output FSM has two states, EMPTY and FULL.
  - EMPTY -> FULL on acceptance.
  - FULL -> EMPTY on out_ready with no acceptance.
  - FULL -> FULL on simultaneous consume and accept; the new a loads that edge.
  - out_valid = (state == FULL).
REQ-023 Latency: a for accepted s_k SHALL appear with out_valid exactly 1 cycle after acceptance.
REQ-024 Throughput: 1 sample/cycle while out_ready = 1.
REQ-025 Stall: a and out_valid SHALL hold stable while out_valid && !out_ready, and no sample is accepted.
REQ-026 Accepted-sample counter: 3 bits, saturates at 4; primed = (count == 4), registered.
REQ-027 in_valid is ignored while in_ready = 0; s with in_valid = 0 SHALL not change any state.

Reset
REQ-028 While reset = 1 at a clock edge, all of the following SHALL be zero at that edge: prior-sum, shift, counter, a, out_valid, primed, err; the FSM SHALL be EMPTY.
REQ-029 During reset cycles, in_ready SHALL read 1 (FSM EMPTY) but no acceptance takes effect.
REQ-030 Reset mid-stream SHALL discard all history; the next accepted s is treated as s_0.

Verification
REQ-031 Ramp, out_ready = 1, w = 16: s = 1,3,6,10,14 on consecutive cycles -> a = 1,2,3,4,5, one cycle later each; primed = 1 from the 4th output; err = 0.
REQ-032 Full scale: s = 65535, 131070, 196605, 262140, 262140 -> a = 65535 five times; err = 0.
REQ-033 Backpressure: feed the REQ-031 stream with out_ready = 0 for 3 cycles after the first output.
  - Expected: a holds 1, out_valid = 1, in_ready = 0.
  - Then out_ready = 1 -> remaining 2,3,4,5 in order, none lost or duplicated.
REQ-034 Bubbles: in_valid toggled 1,0,1,0 with the REQ-031 values -> the same outputs, each 1 cycle after its acceptance; out_valid drops in gap cycles.
REQ-035 Error: s = 5 then s = 0 -> r = -5 -> a = 0xFFFB, err = 1 and it stays 1 over later valid samples until reset.
REQ-036 Reset mid-stream: after s = 1,3,6, assert reset 1 cycle, then s = 2,4 -> a = 2,2, primed = 0, err = 0.
